// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the core load/store port.
// Ports: clk, reset, wr, rd, addr, funct3, wr_data -> rd_data, ready, err.
module dmem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              ready,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [ADDR_W-1:0] OFS1 = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFS2 = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] OFS3 = ADDR_W'(3);

  logic [7:0] mem [0:DEPTH-1];

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              l_rd;
  logic              l_err;
  logic [ADDR_W-1:0] l_addr;
  logic [2:0]        l_f3;

  logic req;
  logic accept;
  logic f3_ok;
  logic misal;
  logic acc_err;
  logic st_en;

  logic [ADDR_W-1:0] ld_addr;
  logic [2:0]        ld_f3;
  logic [7:0]        b0;
  logic [7:0]        b1;
  logic [7:0]        b2;
  logic [7:0]        b3;
  logic [31:0]       ld_val;

  assign req    = wr | rd;
  assign accept = (state == S_IDLE) & req;

  always_comb begin
    f3_ok = 1'b0;
    case (funct3)
      3'b000,
      3'b001,
      3'b010:  f3_ok = 1'b1;
      3'b100,
      3'b101:  f3_ok = ~wr;
      default: f3_ok = 1'b0;
    endcase
  end

  assign misal =
    ((funct3[1:0] == 2'b01) & addr[0]) |
    ((funct3 == 3'b010) & (addr[1:0] != 2'b00));

  assign acc_err = (wr & rd) | ~f3_ok | misal;
  assign st_en   = accept & wr & ~acc_err;

  // Stores land on the acceptance edge; storage has no reset.
  always_ff @(posedge clk) begin
    if (st_en) begin
      mem[addr] <= wr_data[7:0];
      if (funct3[0] | funct3[1])
        mem[addr + OFS1] <= wr_data[15:8];
      if (funct3[1]) begin
        mem[addr + OFS2] <= wr_data[23:16];
        mem[addr + OFS3] <= wr_data[31:24];
      end
    end
  end

  // With zero wait states the load resolves on the
  // acceptance edge, so read from the live request.
  assign ld_addr = (state == S_IDLE) ? addr   : l_addr;
  assign ld_f3   = (state == S_IDLE) ? funct3 : l_f3;

  assign b0 = mem[ld_addr];
  assign b1 = mem[ld_addr + OFS1];
  assign b2 = mem[ld_addr + OFS2];
  assign b3 = mem[ld_addr + OFS3];

  always_comb begin
    ld_val = 32'h0;
    unique case (ld_f3)
      3'b000:  ld_val = {{24{b0[7]}}, b0};
      3'b001:  ld_val = {{16{b1[7]}}, b1, b0};
      3'b010:  ld_val = {b3, b2, b1, b0};
      3'b100:  ld_val = {24'h0, b0};
      3'b101:  ld_val = {16'h0, b1, b0};
      default: ld_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      l_rd    <= 1'b0;
      l_err   <= 1'b0;
      l_addr  <= '0;
      l_f3    <= 3'b000;
      rd_data <= 32'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            l_rd   <= rd;
            l_err  <= acc_err;
            l_addr <= addr;
            l_f3   <= funct3;
            cnt    <= CNT_INIT;
            if (WAIT_CYCLES > 0) begin
              state <= S_WAIT;
            end else begin
              state <= S_RESP;
              if (rd)
                rd_data <= acc_err ? 32'h0 : ld_val;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
            if (l_rd)
              rd_data <= l_err ? 32'h0 : ld_val;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = (state == S_RESP);
  assign err   = ready & l_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder,
// one instance with two wait states and one with none.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  int          cyc;
  int          checks;
  int          errors;

  logic        wr2, rd2, rdy2, err2;
  logic [8:0]  addr2;
  logic [2:0]  f3_2;
  logic [31:0] wd2, rdd2;

  logic        wr0, rd0, rdy0, err0;
  logic [8:0]  addr0;
  logic [2:0]  f3_0;
  logic [31:0] wd0, rdd0;

  dmem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .reset(reset),
    .wr(wr2), .rd(rd2), .addr(addr2),
    .funct3(f3_2), .wr_data(wd2),
    .rd_data(rdd2), .ready(rdy2), .err(err2)
  );

  dmem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset),
    .wr(wr0), .rd(rd0), .addr(addr0),
    .funct3(f3_0), .wr_data(wd0),
    .rd_data(rdd0), .ready(rdy0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one request from a negedge in IDLE and waits for ready.
  // Returns latency in cycles, err/rd_data at ready, the ready
  // level one cycle later, and the cycle stamp of the pulse.
  task automatic acc(
    input  bit          z,
    input  logic        w,
    input  logic        r,
    input  logic [8:0]  a,
    input  logic [2:0]  f,
    input  logic [31:0] d,
    output int          lat,
    output logic        e,
    output logic [31:0] q,
    output logic        nxt,
    output int          rc
  );
    lat = -1;
    e   = 1'bx;
    q   = 32'hx;
    rc  = -1;
    if (z) begin
      wr0 = w; rd0 = r; addr0 = a; f3_0 = f; wd0 = d;
    end else begin
      wr2 = w; rd2 = r; addr2 = a; f3_2 = f; wd2 = d;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (z ? rdy0 : rdy2) begin
        lat = k;
        e   = z ? err0 : err2;
        q   = z ? rdd0 : rdd2;
        rc  = cyc;
        break;
      end
    end
    wr0 = 1'b0; rd0 = 1'b0;
    wr2 = 1'b0; rd2 = 1'b0;
    @(negedge clk);
    nxt = z ? rdy0 : rdy2;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks += 6;
    if (rdy2 !== 1'b0) begin
      errors++; $display("FAIL reset_ready2 got %b want 0", rdy2);
    end
    if (err2 !== 1'b0) begin
      errors++; $display("FAIL reset_err2 got %b want 0", err2);
    end
    if (rdd2 !== 32'h0) begin
      errors++; $display("FAIL reset_rdata2 got %h want 0", rdd2);
    end
    if (rdy0 !== 1'b0) begin
      errors++; $display("FAIL reset_ready0 got %b want 0", rdy0);
    end
    if (err0 !== 1'b0) begin
      errors++; $display("FAIL reset_err0 got %b want 0", err0);
    end
    if (rdd0 !== 32'h0) begin
      errors++; $display("FAIL reset_rdata0 got %h want 0", rdd0);
    end
    reset = 1'b0;
  endtask

  task automatic test_word;
    int lat, rc; logic e, nxt; logic [31:0] q;
    acc(0, 1, 0, 9'd8, 3'b010, 32'hDEADBEEF, lat, e, q, nxt, rc);
    checks += 3;
    if (lat !== 3) begin
      errors++; $display("FAIL sw_latency got %0d want 3", lat);
    end
    if (e !== 1'b0) begin
      errors++; $display("FAIL sw_err got %b want 0", e);
    end
    if (nxt !== 1'b0) begin
      errors++; $display("FAIL sw_pulse got %b want 0", nxt);
    end
    acc(0, 0, 1, 9'd8, 3'b010, 32'h0, lat, e, q, nxt, rc);
    checks += 4;
    if (lat !== 3) begin
      errors++; $display("FAIL lw_latency got %0d want 3", lat);
    end
    if (e !== 1'b0) begin
      errors++; $display("FAIL lw_err got %b want 0", e);
    end
    if (q !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_data got %h want deadbeef", q);
    end
    if (nxt !== 1'b0) begin
      errors++; $display("FAIL lw_pulse got %b want 0", nxt);
    end
  endtask

  task automatic test_byte;
    int lat, rc; logic e, nxt; logic [31:0] q;
    acc(0, 1, 0, 9'd12, 3'b010, 32'h44332211, lat, e, q, nxt, rc);
    acc(0, 1, 0, 9'd13, 3'b000, 32'hAAAAAA80, lat, e, q, nxt, rc);
    checks++;
    if (e !== 1'b0) begin
      errors++; $display("FAIL sb_err got %b want 0", e);
    end
    acc(0, 0, 1, 9'd13, 3'b000, 32'h0, lat, e, q, nxt, rc);
    checks++;
    if (q !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_data got %h want ffffff80", q);
    end
    acc(0, 0, 1, 9'd13, 3'b100, 32'h0, lat, e, q, nxt, rc);
    checks++;
    if (q !== 32'h00000080) begin
      errors++; $display("FAIL lbu_data got %h want 00000080", q);
    end
    acc(0, 0, 1, 9'd12, 3'b010, 32'h0, lat, e, q, nxt, rc);
    checks++;
    if (q !== 32'h44338011) begin
      errors++; $display("FAIL sb_lanes got %h want 44338011", q);
    end
  endtask

  task automatic test_misalign;
    int lat, rc; logic e, nxt; logic [31:0] q;
    acc(0, 1, 0, 9'd4, 3'b010, 32'h11223344, lat, e, q, nxt, rc);
    acc(0, 0, 1, 9'd5, 3'b001, 32'h0, lat, e, q, nxt, rc);
    checks += 3;
    if (lat !== 3) begin
      errors++; $display("FAIL lh_mis_latency got %0d want 3", lat);
    end
    if (e !== 1'b1) begin
      errors++; $display("FAIL lh_mis_err got %b want 1", e);
    end
    if (q !== 32'h0) begin
      errors++; $display("FAIL lh_mis_data got %h want 0", q);
    end
    acc(0, 0, 1, 9'd4, 3'b010, 32'h0, lat, e, q, nxt, rc);
    checks += 2;
    if (e !== 1'b0) begin
      errors++; $display("FAIL lw4_err got %b want 0", e);
    end
    if (q !== 32'h11223344) begin
      errors++; $display("FAIL lw4_data got %h want 11223344", q);
    end
  endtask

  task automatic test_invalid;
    int lat, rc; logic e, nxt; logic [31:0] q;
    acc(0, 1, 0, 9'd0, 3'b010, 32'h01020304, lat, e, q, nxt, rc);
    acc(0, 1, 0, 9'd508, 3'b010, 32'h0A0B0C0D, lat, e, q, nxt, rc);
    acc(0, 1, 1, 9'd0, 3'b010, 32'hFFFFFFFF, lat, e, q, nxt, rc);
    checks += 2;
    if (lat !== 3) begin
      errors++; $display("FAIL wrrd_latency got %0d want 3", lat);
    end
    if (e !== 1'b1) begin
      errors++; $display("FAIL wrrd_err got %b want 1", e);
    end
    acc(0, 1, 0, 9'd0, 3'b100, 32'hFFFFFFFF, lat, e, q, nxt, rc);
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL sbu_err got %b want 1", e);
    end
    acc(0, 1, 0, 9'd510, 3'b010, 32'hFFFFFFFF, lat, e, q, nxt, rc);
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL sw510_err got %b want 1", e);
    end
    acc(0, 0, 1, 9'd0, 3'b010, 32'h0, lat, e, q, nxt, rc);
    checks++;
    if (q !== 32'h01020304) begin
      errors++; $display("FAIL inv_keep0 got %h want 01020304", q);
    end
    acc(0, 0, 1, 9'd508, 3'b010, 32'h0, lat, e, q, nxt, rc);
    checks++;
    if (q !== 32'h0A0B0C0D) begin
      errors++; $display("FAIL inv_keep508 got %h want 0a0b0c0d", q);
    end
  endtask

  task automatic test_back_to_back;
    int lat, rc, rc1; logic e, nxt; logic [31:0] q;
    acc(1, 1, 0, 9'd508, 3'b010, 32'hCAFEF00D, lat, e, q, nxt, rc1);
    checks += 2;
    if (lat !== 1) begin
      errors++; $display("FAIL w0_sw_latency got %0d want 1", lat);
    end
    if (nxt !== 1'b0) begin
      errors++; $display("FAIL w0_pulse got %b want 0", nxt);
    end
    acc(1, 0, 1, 9'd508, 3'b010, 32'h0, lat, e, q, nxt, rc);
    checks += 4;
    if (lat !== 1) begin
      errors++; $display("FAIL w0_lw_latency got %0d want 1", lat);
    end
    if (q !== 32'hCAFEF00D) begin
      errors++; $display("FAIL w0_lw_data got %h want cafef00d", q);
    end
    if (e !== 1'b0) begin
      errors++; $display("FAIL w0_lw_err got %b want 0", e);
    end
    if (rc - rc1 !== 2) begin
      errors++; $display("FAIL w0_period got %0d want 2", rc - rc1);
    end
    acc(1, 0, 1, 9'd510, 3'b001, 32'h0, lat, e, q, nxt, rc);
    checks++;
    if (q !== 32'hFFFFCAFE) begin
      errors++; $display("FAIL w0_lh_data got %h want ffffcafe", q);
    end
    acc(1, 0, 1, 9'd508, 3'b100, 32'h0, lat, e, q, nxt, rc);
    checks++;
    if (q !== 32'h0000000D) begin
      errors++; $display("FAIL w0_lbu_data got %h want 0000000d", q);
    end
  endtask

  task automatic test_reset_mid;
    int lat, rc, pulses; logic e, nxt; logic [31:0] q;
    wr2 = 1'b1; rd2 = 1'b0; addr2 = 9'd16;
    f3_2 = 3'b010; wd2 = 32'h55AA55AA;
    @(negedge clk);
    wr2 = 1'b0;
    reset = 1'b1;
    #1;
    checks += 3;
    if (rdy2 !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready got %b want 0", rdy2);
    end
    if (err2 !== 1'b0) begin
      errors++; $display("FAIL rstmid_err got %b want 0", err2);
    end
    if (rdd2 !== 32'h0) begin
      errors++; $display("FAIL rstmid_rdata got %h want 0", rdd2);
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rdy2) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL rstmid_pulses got %0d want 0", pulses);
    end
    acc(0, 0, 1, 9'd16, 3'b010, 32'h0, lat, e, q, nxt, rc);
    checks += 2;
    if (lat !== 3) begin
      errors++; $display("FAIL rstmid_lw_latency got %0d want 3", lat);
    end
    if (q !== 32'h55AA55AA) begin
      errors++; $display("FAIL rstmid_lw_data got %h want 55aa55aa", q);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wr2 = 0; rd2 = 0; addr2 = 0; f3_2 = 0; wd2 = 0;
    wr0 = 0; rd0 = 0; addr0 = 0; f3_0 = 0; wd0 = 0;
    test_reset();
    test_word();
    test_byte();
    test_misalign();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
